instr_axil_slave: RTL

INSTR_AXIL_SLAVE -- requirements
Module: instr_axil_slave

---
 rtl/instr_axil_pkg.sv | 22 ++
 rtl/instr_axil_wstrb_merge.sv | 20 ++
 rtl/instr_axil_slave.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/instr_axil_pkg.sv
// rtl/instr_axil_pkg.sv - register map, AXI response codes and FSM state types for instr_axil_slave
package instr_axil_pkg;

    localparam int NUM_REGS = 4;

    localparam logic [4:0] REG0_OFFSET = 5'h00;
    localparam logic [4:0] REG1_OFFSET = 5'h04;
    localparam logic [4:0] REG2_OFFSET = 5'h08;
    localparam logic [4:0] REG3_OFFSET = 5'h0C;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

    // Word-granular match: the two byte-lane address bits never take part.
    function automatic logic addr_is_reg(input logic [4:0] addr, input logic [4:0] offset);
        return addr[4:2] == offset[4:2];
    endfunction

endpackage

// File: rtl/instr_axil_wstrb_merge.sv
// rtl/instr_axil_wstrb_merge.sv - per-byte merge of new write data into an old register value
module instr_axil_wstrb_merge #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]   old_value,
    input  logic [DATA_WIDTH-1:0]   new_data,
    input  logic [DATA_WIDTH/8-1:0] strobe,
    output logic [DATA_WIDTH-1:0]   merged_value
);

    always_comb begin
        merged_value = old_value;
        for (int b = 0; b < DATA_WIDTH / 8; b++) begin
            if (strobe[b]) begin
                merged_value[b*8 +: 8] = new_data[b*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/instr_axil_slave.sv
// rtl/instr_axil_slave.sv - AXI4-Lite slave with four 32-bit registers for an instrument block
// Optional feature macro INSTR_CAPTURE_EN: REG3 becomes a read-only capture of sample_data.
module instr_axil_slave
    import instr_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   ctrl_out,
    input  logic                            sample_valid,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   sample_data
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = DW / 8;

    wr_state_t           wr_state;
    rd_state_t           rd_state;
    logic                aw_latched;
    logic                w_latched;
    logic [4:0]          awaddr_q;
    logic [DW-1:0]       wdata_q;
    logic [SW-1:0]       wstrb_q;
    logic [DW-1:0]       regs   [NUM_REGS];
    logic [DW-1:0]       merged [NUM_REGS];
    logic [NUM_REGS-1:0] wr_sel;
    logic [NUM_REGS-1:0] rd_sel;
    logic [DW-1:0]       rd_value;
    logic                wr_commit;

    assign wr_commit = (wr_state == W_IDLE) && aw_latched && w_latched;
    assign ctrl_out  = regs[0];

    always_comb begin
        wr_sel = {addr_is_reg(awaddr_q, REG3_OFFSET), addr_is_reg(awaddr_q, REG2_OFFSET),
                  addr_is_reg(awaddr_q, REG1_OFFSET), addr_is_reg(awaddr_q, REG0_OFFSET)};
`ifdef INSTR_CAPTURE_EN
        wr_sel[3] = 1'b0;
`endif
    end

    assign rd_sel = {addr_is_reg(s00_axi_araddr[4:0], REG3_OFFSET),
                     addr_is_reg(s00_axi_araddr[4:0], REG2_OFFSET),
                     addr_is_reg(s00_axi_araddr[4:0], REG1_OFFSET),
                     addr_is_reg(s00_axi_araddr[4:0], REG0_OFFSET)};

    always_comb begin
        rd_value = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_sel[i]) begin
                rd_value = regs[i];
            end
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_merge
        instr_axil_wstrb_merge #(
            .DATA_WIDTH (DW)
        ) u_merge (
            .old_value    (regs[i]),
            .new_data     (wdata_q),
            .strobe       (wstrb_q),
            .merged_value (merged[i])
        );
    end

    // AW and W latch independently; the commit fires once both flags are set.
    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            wr_state        <= W_IDLE;
            aw_latched      <= 1'b0;
            w_latched       <= 1'b0;
            awaddr_q        <= '0;
            wdata_q         <= '0;
            wstrb_q         <= '0;
            s00_axi_awready <= 1'b0;
            s00_axi_wready  <= 1'b0;
            s00_axi_bvalid  <= 1'b0;
            s00_axi_bresp   <= RESP_OKAY;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    s00_axi_awready <= s00_axi_awvalid && !s00_axi_awready && !aw_latched;
                    s00_axi_wready  <= s00_axi_wvalid && !s00_axi_wready && !w_latched;
                    if (s00_axi_awvalid && s00_axi_awready) begin
                        aw_latched <= 1'b1;
                        awaddr_q   <= s00_axi_awaddr[4:0];
                    end
                    if (s00_axi_wvalid && s00_axi_wready) begin
                        w_latched <= 1'b1;
                        wdata_q   <= s00_axi_wdata;
                        wstrb_q   <= s00_axi_wstrb;
                    end
                    if (wr_commit) begin
                        aw_latched     <= 1'b0;
                        w_latched      <= 1'b0;
                        s00_axi_bvalid <= 1'b1;
                        s00_axi_bresp  <= (|wr_sel) ? RESP_OKAY : RESP_SLVERR;
                        wr_state       <= W_RESP;
                    end
                end
                W_RESP: begin
                    s00_axi_awready <= 1'b0;
                    s00_axi_wready  <= 1'b0;
                    if (s00_axi_bready) begin
                        s00_axi_bvalid <= 1'b0;
                        wr_state       <= W_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_commit && wr_sel[i]) begin
                    regs[i] <= merged[i];
                end
            end
`ifdef INSTR_CAPTURE_EN
            if (sample_valid) begin
                regs[3] <= sample_data;
            end
`endif
        end
    end

    // Read data is sampled at the AR handshake edge, so a same-edge write is not yet visible.
    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            rd_state        <= R_IDLE;
            s00_axi_arready <= 1'b0;
            s00_axi_rvalid  <= 1'b0;
            s00_axi_rdata   <= '0;
            s00_axi_rresp   <= RESP_OKAY;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    s00_axi_arready <= s00_axi_arvalid && !s00_axi_arready;
                    if (s00_axi_arvalid && s00_axi_arready) begin
                        s00_axi_rvalid <= 1'b1;
                        s00_axi_rdata  <= rd_value;
                        s00_axi_rresp  <= (|rd_sel) ? RESP_OKAY : RESP_SLVERR;
                        rd_state       <= R_DATA;
                    end
                end
                R_DATA: begin
                    s00_axi_arready <= 1'b0;
                    if (s00_axi_rready) begin
                        s00_axi_rvalid <= 1'b0;
                        rd_state       <= R_IDLE;
                    end
                end
            endcase
        end
    end

    logic unused_ok;
`ifdef INSTR_CAPTURE_EN
    assign unused_ok = &{1'b0, s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr, s00_axi_araddr};
`else
    assign unused_ok = &{1'b0, s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr, s00_axi_araddr,
                         sample_valid, sample_data};
`endif

endmodule
